// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer for a
// single-port byte RAM. Each requester hands over one read or write command
// through a req/ack handshake. The arbiter issues a single-cycle wen/ren
// strobe, waits out the RAM read latency, returns read data and pulses ack.
module ram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    // requester 0
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    // requester 1
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    // RAM side
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_datain,
    output logic              ram_wen,
    output logic              ram_ren,
    input  logic [DATA_W-1:0] ram_q,
    // status
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    // The wait counter only ever holds RD_LAT-1 down to 0.
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              last_grant;   // requester that won the previous grant
    logic              grant;        // requester owning the current command
    logic              win;          // requester that would win in IDLE now
    logic              any_req;

    // Command captured at grant; requester inputs are ignored afterwards.
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    assign any_req = req0 | req1;

    // Round-robin winner: a lone requester wins, contention goes to the one
    // that was not granted last time.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last_grant;
        end else if (req1) begin
            win = 1'b1;
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> (WAIT) -> ACK sequence.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = cmd_we ? ACK : WAIT;
            WAIT:    if (wait_cnt == '0) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant bookkeeping and command latch, loaded only on the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            grant      <= 1'b0;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
        end else if (state == IDLE && any_req) begin
            last_grant <= win;
            grant      <= win;
            if (win) begin
                cmd_we    <= we1;
                cmd_addr  <= addr1;
                cmd_wdata <= wdata1;
            end else begin
                cmd_we    <= we0;
                cmd_addr  <= addr0;
                cmd_wdata <= wdata0;
            end
        end
    end

    // Read-latency down-counter: loaded in ISSUE, counts through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    // Read data return: ram_q is captured on the last WAIT cycle into the
    // granted requester's register only; the other one is left untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == WAIT && wait_cnt == '0) begin
            if (grant) begin
                rdata1 <= ram_q;
            end else begin
                rdata0 <= ram_q;
            end
        end
    end

    // RAM address/data come straight from the command latch, so they hold
    // their last value outside ISSUE; strobes are decoded from the state.
    assign ram_address = cmd_addr;
    assign ram_datain  = cmd_wdata;
    assign ram_wen     = (state == ISSUE) &&  cmd_we;
    assign ram_ren     = (state == ISSUE) && !cmd_we;
    assign ack0        = (state == ACK) && !grant;
    assign ack1        = (state == ACK) &&  grant;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter. A behavioural RAM sits
// behind each DUT; a transaction-level reference model (round-robin rule,
// per-kind latency, byte memory) predicts strobes, acks, rdata and busy.
module tb_ram_arbiter;

    localparam int RD_LAT   = 1;
    localparam int RD_LAT_B = 2;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A (RD_LAT = 1) ----------------
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        ack0, ack1;
    logic [7:0]  rdata0, rdata1;
    logic [15:0] ram_address;
    logic [7:0]  ram_datain, ram_q;
    logic        ram_wen, ram_ren, busy;

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .ram_address(ram_address), .ram_datain(ram_datain),
        .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_q(ram_q), .busy(busy)
    );

    logic [7:0] mem_a [0:65535];
    always @(posedge clk) begin
        if (ram_wen) mem_a[ram_address] <= ram_datain;
        if (ram_ren) ram_q <= mem_a[ram_address];
    end

    // ---------------- DUT B (RD_LAT = 2) ----------------
    logic        b_req0, b_we0, b_req1, b_we1;
    logic [15:0] b_addr0, b_addr1;
    logic [7:0]  b_wdata0, b_wdata1;
    logic        b_ack0, b_ack1;
    logic [7:0]  b_rdata0, b_rdata1;
    logic [15:0] b_ram_address;
    logic [7:0]  b_ram_datain, b_ram_q, b_pipe;
    logic        b_ram_wen, b_ram_ren, b_busy;

    ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(RD_LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
        .ram_address(b_ram_address), .ram_datain(b_ram_datain),
        .ram_wen(b_ram_wen), .ram_ren(b_ram_ren), .ram_q(b_ram_q), .busy(b_busy)
    );

    logic [7:0] mem_b [0:65535];
    always @(posedge clk) begin
        if (b_ram_wen) mem_b[b_ram_address] <= b_ram_datain;
        if (b_ram_ren) b_pipe <= mem_b[b_ram_address];
        b_ram_q <= b_pipe;
    end

    // ---------------- reference model state ----------------
    int vec  = 0;
    int miss = 0;

    cmd_t       q0[$], q1[$];
    logic [7:0] ref_mem [int];
    int         gap0, gap1;
    bit         rand_gap;
    int         last_m;
    int         grant_pend;
    int         exp_who, exp_cyc;
    bit         exp_rd;
    logic [7:0] exp_data;
    int         busy_to;
    logic [7:0] m_rd0, m_rd1;
    logic       prev_wen;
    int         ack_who_log[$];
    int         ack_cyc_log[$];

    function automatic cmd_t mk(input logic we, input logic [15:0] a, input logic [7:0] d);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d;
        return c;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    task automatic model_reset();
        q0.delete(); q1.delete();
        gap0 = 0; gap1 = 0;
        last_m = 1; grant_pend = -1;
        exp_who = -1; exp_cyc = -1; exp_rd = 0; exp_data = '0;
        busy_to = -1;
        m_rd0 = '0; m_rd1 = '0;
        prev_wen = 1'b0;
        req0 = 0; req1 = 0;
    endtask

    // One clock of checking against the model, then drive the next inputs.
    task automatic step();
        cmd_t c;
        logic e0, e1;
        int   w;
        @(negedge clk);
        if (grant_pend >= 0) begin
            c = (grant_pend == 0) ? q0[0] : q1[0];
            vec++;
            if (ram_wen !== c.we || ram_ren !== ~c.we || ram_address !== c.addr ||
                (c.we && ram_datain !== c.wdata)) begin
                miss++;
                $display("FAIL issue @%0d: wen=%b ren=%b addr=%h din=%h, required we=%b addr=%h din=%h",
                         cyc, ram_wen, ram_ren, ram_address, ram_datain, c.we, c.addr, c.wdata);
            end
            exp_who = grant_pend;
            exp_cyc = cyc + (c.we ? 1 : RD_LAT + 1);
            exp_rd  = ~c.we;
            if (c.we) ref_mem[int'(c.addr)] = c.wdata;
            else      exp_data = ref_rd(c.addr);
            busy_to    = exp_cyc;
            grant_pend = -1;
        end else begin
            vec++;
            if (ram_wen !== 1'b0 || ram_ren !== 1'b0) begin
                miss++;
                $display("FAIL stray_strobe @%0d: wen=%b ren=%b, required 0 0", cyc, ram_wen, ram_ren);
            end
        end
        vec++;
        if (ram_wen === 1'b1 && prev_wen === 1'b1) begin
            miss++;
            $display("FAIL wen_twice @%0d: wen high two cycles running, required single-cycle", cyc);
        end
        prev_wen = ram_wen;

        e0 = (exp_who == 0 && exp_cyc == cyc);
        e1 = (exp_who == 1 && exp_cyc == cyc);
        vec++;
        if (ack0 !== e0 || ack1 !== e1) begin
            miss++;
            $display("FAIL ack @%0d: ack0=%b ack1=%b, required %b %b", cyc, ack0, ack1, e0, e1);
        end
        if (e0 || e1) begin
            if (exp_rd) begin
                if (e0) m_rd0 = exp_data;
                else    m_rd1 = exp_data;
            end
            ack_who_log.push_back(exp_who);
            ack_cyc_log.push_back(cyc);
            if (e0) begin
                void'(q0.pop_front());
                gap0 = rand_gap ? int'($urandom_range(3, 0)) : 0;
            end else begin
                void'(q1.pop_front());
                gap1 = rand_gap ? int'($urandom_range(3, 0)) : 0;
            end
            exp_who = -1;
        end
        vec++;
        if (rdata0 !== m_rd0 || rdata1 !== m_rd1) begin
            miss++;
            $display("FAIL rdata @%0d: rdata0=%h rdata1=%h, required %h %h", cyc, rdata0, rdata1, m_rd0, m_rd1);
        end
        vec++;
        if (busy !== (busy_to >= cyc)) begin
            miss++;
            $display("FAIL busy @%0d: busy=%b, required %b", cyc, busy, (busy_to >= cyc));
        end

        // Requesters: hold the queue head until its ack, optional idle gap.
        if (gap0 > 0) begin req0 = 0; gap0--; end
        else req0 = (q0.size() != 0);
        if (q0.size() != 0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
        if (gap1 > 0) begin req1 = 0; gap1--; end
        else req1 = (q1.size() != 0);
        if (q1.size() != 0) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata; end

        // Arbitration happens at the edge ending an idle cycle.
        if (busy_to < cyc && (req0 || req1)) begin
            if (req0 && req1) w = 1 - last_m;
            else              w = req0 ? 0 : 1;
            last_m     = w;
            grant_pend = w;
        end
    endtask

    task automatic run_until_done(input int max_cyc);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_who >= 0 || grant_pend >= 0) && n < max_cyc) begin
            step();
            n++;
        end
        vec++;
        if (n >= max_cyc) begin
            miss++;
            $display("FAIL timeout: %0d commands still pending after %0d cycles, required 0",
                     q0.size() + q1.size(), max_cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
        b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;
        we0 = 0; addr0 = '0; wdata0 = '0; we1 = 0; addr1 = '0; wdata1 = '0;
        #2;
        vec++;
        if ({ram_wen, ram_ren, ack0, ack1, busy, rdata0, rdata1, ram_address, ram_datain} !== '0) begin
            miss++;
            $display("FAIL reset_outputs: wen=%b ren=%b ack=%b%b busy=%b rd=%h/%h addr=%h din=%h, required all 0",
                     ram_wen, ram_ren, ack0, ack1, busy, rdata0, rdata1, ram_address, ram_datain);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_single_write();
        ack_who_log.delete(); ack_cyc_log.delete();
        q0.push_back(mk(1'b1, 16'd0, 8'd2));
        run_until_done(20);
        vec++;
        if (ack_who_log.size() != 1 || ack_who_log[0] != 0) begin
            miss++;
            $display("FAIL single_write_acks: %0d acks, required exactly one ack0", ack_who_log.size());
        end
    endtask

    task automatic test_read_back();
        q1.push_back(mk(1'b1, 16'd1, 8'd255));
        q1.push_back(mk(1'b0, 16'd1, 8'd0));
        run_until_done(30);
        vec++;
        if (rdata1 !== 8'd255 || rdata0 !== 8'd0) begin
            miss++;
            $display("FAIL read_back: rdata1=%h rdata0=%h, required ff 00", rdata1, rdata0);
        end
    endtask

    task automatic test_contention();
        do_reset();
        ack_who_log.delete(); ack_cyc_log.delete();
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk(1'b0, 16'd0, 8'd0));
            q1.push_back(mk(1'b0, 16'd1, 8'd0));
        end
        run_until_done(60);
        vec++;
        if (ack_who_log.size() != 4) begin
            miss++;
            $display("FAIL contention_count: %0d acks, required 4", ack_who_log.size());
        end
        for (int i = 0; i < ack_who_log.size(); i++) begin
            vec++;
            if (ack_who_log[i] != (i % 2)) begin
                miss++;
                $display("FAIL grant_order[%0d]: requester %0d, required %0d", i, ack_who_log[i], i % 2);
            end
        end
        vec++;
        if (rdata0 !== 8'd2 || rdata1 !== 8'd255) begin
            miss++;
            $display("FAIL contention_data: rdata0=%h rdata1=%h, required 02 ff", rdata0, rdata1);
        end
    endtask

    task automatic test_back_to_back();
        ack_who_log.delete(); ack_cyc_log.delete();
        for (int i = 0; i < 4; i++)
            q0.push_back(mk(1'b1, 16'(4 + i), 8'($urandom_range(255, 0))));
        run_until_done(40);
        vec++;
        if (ack_cyc_log.size() != 4) begin
            miss++;
            $display("FAIL b2b_count: %0d acks, required 4", ack_cyc_log.size());
        end
        for (int i = 1; i < ack_cyc_log.size(); i++) begin
            vec++;
            if (ack_cyc_log[i] - ack_cyc_log[i-1] != 3) begin
                miss++;
                $display("FAIL b2b_spacing[%0d]: %0d cycles, required 3", i, ack_cyc_log[i] - ack_cyc_log[i-1]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int n;
        q0.push_back(mk(1'b0, 16'd1, 8'd0));
        n = 0;
        while (exp_who < 0 && n < 20) begin step(); n++; end
        vec++;
        if (exp_who < 0 || !exp_rd) begin
            miss++;
            $display("FAIL mid_read_issue: no read issued within 20 cycles, required one");
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vec++;
        if ({ram_wen, ram_ren, ack0, ack1, busy, rdata0, rdata1, ram_address, ram_datain} !== '0) begin
            miss++;
            $display("FAIL mid_read_reset: wen=%b ren=%b ack=%b%b busy=%b rd=%h/%h addr=%h din=%h, required all 0",
                     ram_wen, ram_ren, ack0, ack1, busy, rdata0, rdata1, ram_address, ram_datain);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step();
        q0.push_back(mk(1'b0, 16'd0, 8'd0));
        run_until_done(20);
        vec++;
        if (rdata0 !== 8'd2) begin
            miss++;
            $display("FAIL post_reset_read: rdata0=%h, required 02", rdata0);
        end
    endtask

    task automatic test_random();
        rand_gap = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3, 0) == 0 && q0.size() < 3)
                q0.push_back(mk(1'($urandom_range(1, 0)), 16'($urandom_range(15, 0)), 8'($urandom_range(255, 0))));
            if ($urandom_range(3, 0) == 0 && q1.size() < 3)
                q1.push_back(mk(1'($urandom_range(1, 0)), 16'($urandom_range(15, 0)), 8'($urandom_range(255, 0))));
            step();
        end
        run_until_done(200);
        rand_gap = 1'b0;
    endtask

    task automatic b_txn(input logic we, input logic [15:0] a, input logic [7:0] d,
                         input int lat_exp, input logic [7:0] rd_exp);
        int issue_c, ack_c;
        issue_c = -1; ack_c = -1;
        @(negedge clk);
        b_req0 = 1; b_we0 = we; b_addr0 = a; b_wdata0 = d;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (b_ram_wen || b_ram_ren) issue_c = cyc;
            if (b_ack0) begin ack_c = cyc; break; end
        end
        b_req0 = 0;
        vec++;
        if (issue_c < 0 || ack_c < 0 || ack_c - issue_c != lat_exp) begin
            miss++;
            $display("FAIL lat2_timing we=%b: issue@%0d ack@%0d, required ack at issue+%0d", we, issue_c, ack_c, lat_exp);
        end
        if (!we) begin
            vec++;
            if (b_rdata0 !== rd_exp) begin
                miss++;
                $display("FAIL lat2_rdata: rdata0=%h, required %h", b_rdata0, rd_exp);
            end
        end
    endtask

    task automatic test_rd_lat2();
        b_txn(1'b1, 16'd0, 8'd2, 1, 8'd0);
        b_txn(1'b0, 16'd0, 8'd0, RD_LAT_B + 1, 8'd2);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        ram_q = '0; b_pipe = '0; b_ram_q = '0;
        rand_gap = 1'b0;
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        test_rd_lat2();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the single-port byte RAM (16-bit address, 8-bit data, separate wen/ren strobes).
- Accepts one read or write command per requester through a req/ack handshake.
- Grants the RAM to one requester at a time and generates the single-cycle wen/ren strobe.
- Waits the RAM read latency, captures q and returns it to the requester.
- Sits between the CPU/DMA-style masters and the ram instance.

Parameters:
ADDR_W, 16, RAM address width
DATA_W, 8, RAM data width
RD_LAT, 1, cycles from the cycle ren is high to the cycle ram_q is valid (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 command request
we0  in  1  requester 0: 1=write, 0=read
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
ack0  out  1  requester 0 completion pulse
rdata0  out  DATA_W  requester 0 read data
req1, we1, addr1, wdata1, ack1, rdata1  same as requester 0, for requester 1
ram_address  out  ADDR_W  to RAM address
ram_datain  out  DATA_W  to RAM datain
ram_wen  out  1  to RAM write enable
ram_ren  out  1  to RAM read enable
ram_q  in  DATA_W  from RAM q
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - All outputs 0, state IDLE.
  - Round-robin pointer last_grant=1, so requester 0 wins the first contention.
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Samples req0/req1 each edge.
  - If either is high, the winner's we/addr/wdata are latched into internal command registers. Next state ISSUE.
  - Winner rule: only one requesting -> that one. Both requesting -> the one != last_grant. last_grant updates on grant.
- ISSUE (1 cycle):
  - ram_address/ram_datain driven from the latched command.
  - Exactly one of ram_wen/ram_ren = 1.
  - Write -> ACK. Read -> WAIT.
- WAIT (RD_LAT cycles, down-counter):
  - ram_wen = ram_ren = 0.
  - On the last WAIT cycle, ram_q is registered into the granted requester's rdata. Next state ACK.
- ACK (1 cycle):
  - The granted requester's ack = 1 for exactly this cycle. Next state IDLE.
  - rdata is valid during ack and held until that requester's next read completes.
  - The other requester's rdata is never disturbed.
- Timing, with the grant edge ending IDLE and ISSUE in cycle N:
  - Write: ack at N+1.
  - Read: ack at N+RD_LAT+1.
  - Minimum issue-to-issue spacing is 3 cycles (write) or RD_LAT+3 cycles (read), because IDLE always occupies one cycle.
- Requester protocol:
  - Hold req, we, addr and wdata stable until ack.
  - Drop req in the cycle after ack, or keep it high to request again; the request is re-arbitrated in IDLE.
  - Command inputs are ignored after latching. Dropping req before ack does not abort; the transaction completes and ack is still pulsed.
- Fairness: with both requests held continuously, grants alternate 0,1,0,1. No requester waits more than one foreign transaction.
- Strobes: ram_wen/ram_ren are high only in ISSUE and never both. ram_address/ram_datain hold their last values outside ISSUE.
- Reset mid-operation:
  - All outputs clear immediately (asynchronous), state IDLE, no ack issued.
  - rdata clears to 0 and last_grant returns to 1.

Test Plan:
1. After reset, req0 write addr=0 wdata=2 -> ram_wen=1 with ram_address=0, ram_datain=2 for one cycle; ack0 one cycle later; busy 1 for 2 cycles; ram_ren stays 0.
2. req1 write addr=1 wdata=255, then req1 read addr=1 -> ram_ren one cycle; ack1 at ISSUE+2 (RD_LAT=1) with rdata1=255; rdata0 unchanged.
3. req0 and req1 asserted in the same cycle after reset (reads of addr 0 and 1) -> requester 0 granted first (rdata0=2), then requester 1 (rdata1=255); holding both reqs yields grant order 0,1,0,1.
4. Single requester req0 held high for 4 writes -> ack0 every 3 cycles; ack1 never pulses; ram_wen never asserted two consecutive cycles.
5. rst_n pulled low during WAIT of a read -> ram_ren/ram_wen/ack/busy/rdata go 0 immediately; no ack after release; the next req0 is granted from IDLE normally.
6. RD_LAT=2 build: read addr=0 -> ack0 at ISSUE+3, rdata0=2; write ack timing unchanged (ISSUE+1).
